// File: rtl/cordic_pkg.sv
// Shared definitions for the rotation-CORDIC front end.
//   PHASE_W / AMP_W / CNT_W : angle, amplitude and sample-count widths
//   CORDIC_LATENCY          : input-register to xout/yout delay in clocks
//   ANGLE_45 / ANGLE_90     : common phase constants (2^32 = 360 deg)
//   state_t                 : phase generator FSM states
//   phase_cfg_t             : per-burst phase configuration latched at start
//   sat_amp()               : clamps amplitude into the CORDIC input range
package cordic_pkg;

    localparam int unsigned PHASE_W        = 32;
    localparam int unsigned AMP_W          = 16;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned CORDIC_LATENCY = 16;

    localparam logic [PHASE_W-1:0] ANGLE_45 = 32'h2000_0000;
    localparam logic [PHASE_W-1:0] ANGLE_90 = 32'h4000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] freq_word;
        logic [PHASE_W-1:0] phase_off;
    } phase_cfg_t;

    // Negative amplitudes are forced to positive full scale.
    function automatic logic [AMP_W-1:0] sat_amp(input logic [AMP_W-1:0] a);
        return a[AMP_W-1] ? {1'b0, {(AMP_W-1){1'b1}}} : a;
    endfunction

endpackage

// File: rtl/cordic_vld_pipe.sv
// Valid-tracking delay line matching the CORDIC pipeline depth.
//   clk, rst_n   : clock, async active-low clear
//   din          : valid bit entering the CORDIC this cycle
//   dout         : din delayed exactly DEPTH clocks
//   empty_nxt_c  : the line holds no valid bit after the next clock edge
module cordic_vld_pipe #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic empty_nxt_c
);

    logic [DEPTH-1:0] sr;

    // Shift register; the last stage is the delayed valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout        = sr[DEPTH-1];
    // The last stage shifts out next edge, so only din and the lower stages matter.
    assign empty_nxt_c = ~din & ~(|sr[DEPTH-2:0]);

endmodule

// File: rtl/cordic_phase_gen.sv
// Numerically controlled phase source feeding a 16-stage rotation CORDIC.
//   clk, rst_n         : clock, async active-low reset
//   start, stop        : burst request (IDLE only) / abort (RUN only)
//   freq_word          : per-sample phase increment
//   phase_off          : constant phase offset
//   amplitude          : signed rotation magnitude, saturated at start
//   num_samples        : burst length, 0 = continuous until stop
//   xin, yin, angle    : CORDIC inputs
//   angle_vld, out_vld : sample valid at CORDIC input / output
//   busy, done         : RUN or DRAIN / one-cycle completion pulse
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int unsigned LATENCY = CORDIC_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [AMP_W-1:0]   amplitude,
    input  logic [CNT_W-1:0]   num_samples,
    output logic [AMP_W-1:0]   xin,
    output logic [AMP_W-1:0]   yin,
    output logic [PHASE_W-1:0] angle,
    output logic               angle_vld,
    output logic               out_vld,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    phase_cfg_t         cfg_q, cfg_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cont_q, cont_d;
    logic [AMP_W-1:0]   xin_d;
    logic [PHASE_W-1:0] angle_d;
    logic               angle_vld_d;
    logic               busy_d;
    logic               done_d;
    logic               empty_nxt_c;

    cordic_vld_pipe #(.DEPTH(LATENCY)) u_vld_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (angle_vld),
        .dout        (out_vld),
        .empty_nxt_c (empty_nxt_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            cont_q    <= 1'b0;
            xin       <= '0;
            yin       <= '0;
            angle     <= '0;
            angle_vld <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cont_q    <= cont_d;
            xin       <= xin_d;
            yin       <= '0;
            angle     <= angle_d;
            angle_vld <= angle_vld_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state and next-output logic. cnt_q holds samples still to issue
    // after the one leaving this cycle; the start edge issues sample one.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cont_d      = cont_q;
        xin_d       = xin;
        angle_d     = angle;
        angle_vld_d = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d       = '{freq_word: freq_word, phase_off: phase_off};
                    xin_d       = sat_amp(amplitude);
                    cont_d      = (num_samples == '0);
                    cnt_d       = num_samples - CNT_W'(1);
                    angle_d     = phase_off;
                    angle_vld_d = 1'b1;
                    acc_d       = freq_word;
                    busy_d      = 1'b1;
                    state_d     = (num_samples == CNT_W'(1)) ? DRAIN : RUN;
                end
            end
            RUN: begin
                angle_d     = acc_q + cfg_q.phase_off;
                acc_d       = acc_q + cfg_q.freq_word;
                angle_vld_d = 1'b1;
                cnt_d       = cnt_q - CNT_W'(1);
                if (stop || (!cont_q && cnt_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (empty_nxt_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
